// File: rtl/snn_pkg.sv
// snn_pkg: shared widths, neuron function codes and scheduler states
package snn_pkg;
  localparam int DW = 8;
  localparam logic FUNC_INTEGRATE = 1'b0;
  localparam logic FUNC_LEAK_FIRE = 1'b1;
  typedef enum logic [2:0] {IDLE, SCAN, ACC_RD, ACC_WB, LEAK_RD, LEAK_WB, DONE} state_e;
endpackage

// File: rtl/snn_layer_sched.sv
// snn_layer_sched: time-multiplexes one neuron datapath over a layer for one timestep
module snn_layer_sched
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS  = 64,
  parameter int NUM_OUTPUTS = 16,
  parameter int DW          = snn_pkg::DW,
  localparam int IW  = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1,
  localparam int JW  = NUM_OUTPUTS > 1 ? $clog2(NUM_OUTPUTS) : 1,
  localparam int WAW = NUM_INPUTS * NUM_OUTPUTS > 1 ? $clog2(NUM_INPUTS * NUM_OUTPUTS) : 1
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   start,
  input  logic [NUM_INPUTS-1:0]  in_spikes,
  input  logic [DW-1:0]          beta,
  input  logic [DW-1:0]          v_th,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_OUTPUTS-1:0] out_spikes,
  output logic [WAW-1:0]         w_addr,
  input  logic [DW-1:0]          w_rdata,
  output logic [JW-1:0]          vm_addr,
  input  logic [DW-1:0]          vm_rdata,
  output logic                   vm_we,
  output logic [DW-1:0]          vm_wdata,
  output logic [DW-1:0]          nrn_weight,
  output logic [DW-1:0]          nrn_v_mem_in,
  output logic [DW-1:0]          nrn_beta,
  output logic [DW-1:0]          nrn_v_th,
  output logic                   nrn_function_sel,
  input  logic                   nrn_spike,
  input  logic [DW-1:0]          nrn_v_mem_out
);
  state_e state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [NUM_INPUTS-1:0] spk_q, spk_d;
  logic [DW-1:0] beta_q, beta_d, vth_q, vth_d;
  logic [NUM_OUTPUTS-1:0] out_q, out_d;
  logic last_i, last_j;
  assign last_i = i_q == IW'(NUM_INPUTS - 1);
  assign last_j = j_q == JW'(NUM_OUTPUTS - 1);
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign out_spikes = out_q;
  assign w_addr = WAW'(int'(i_q) * NUM_OUTPUTS + int'(j_q));
  assign vm_addr = j_q;
  assign vm_we = (state_q == ACC_WB || state_q == LEAK_WB) && !wb_rst_i;
  assign vm_wdata = nrn_v_mem_out;
  assign nrn_weight = state_q == ACC_WB ? w_rdata : '0;
  assign nrn_v_mem_in = vm_rdata;
  assign nrn_beta = beta_q;
  assign nrn_v_th = vth_q;
  assign nrn_function_sel = (state_q == LEAK_RD || state_q == LEAK_WB) ? FUNC_LEAK_FIRE : FUNC_INTEGRATE;
  // next-state: scan inputs, integrate weight rows of set spikes, then leak/fire every neuron
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    spk_d = spk_q;
    beta_d = beta_q;
    vth_d = vth_q;
    out_d = out_q;
    case (state_q)
      IDLE: if (start) begin
        spk_d = in_spikes;
        beta_d = beta;
        vth_d = v_th;
        i_d = '0;
        state_d = SCAN;
      end
      SCAN: if (spk_q[i_q]) begin
        j_d = '0;
        state_d = ACC_RD;
      end else if (last_i) begin
        j_d = '0;
        state_d = LEAK_RD;
      end else i_d = i_q + 1'b1;
      ACC_RD: state_d = ACC_WB;
      ACC_WB: if (!last_j) begin
        j_d = j_q + 1'b1;
        state_d = ACC_RD;
      end else if (last_i) begin
        j_d = '0;
        state_d = LEAK_RD;
      end else begin
        i_d = i_q + 1'b1;
        state_d = SCAN;
      end
      LEAK_RD: state_d = LEAK_WB;
      LEAK_WB: begin
        out_d[j_q] = nrn_spike;
        j_d = last_j ? j_q : j_q + 1'b1;
        state_d = last_j ? DONE : LEAK_RD;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state, counters and latched timestep operands
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      i_q <= '0;
      j_q <= '0;
      spk_q <= '0;
      beta_q <= '0;
      vth_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      spk_q <= spk_d;
      beta_q <= beta_d;
      vth_q <= vth_d;
      out_q <= out_d;
    end
  end
endmodule

// File: tb/tb_snn_layer_sched.sv
// tb_snn_layer_sched: scoreboard bench with behavioural RAMs and a neuron model
module tb_snn_layer_sched;
  localparam int NI = 4, NO = 2;
  logic clk = 0, rst = 1, start = 0;
  logic [NI-1:0] in_spikes = '0;
  logic [7:0] beta = '0, v_th = '0;
  logic busy, done, vm_we, nrn_function_sel, nrn_spike;
  logic [NO-1:0] out_spikes;
  logic [2:0] w_addr;
  logic [0:0] vm_addr;
  logic [7:0] w_rdata, vm_rdata, vm_wdata, nrn_weight, nrn_v_mem_in, nrn_beta, nrn_v_th, nrn_v_mem_out;
  logic [7:0] wram [8];
  logic [7:0] vram [2];
  logic vload = 0;
  logic [7:0] vinit0 = '0, vinit1 = '0;
  logic [8:0] nsum;
  logic [15:0] nprod;
  typedef struct {logic [0:0] a; logic sel; logic [2:0] wa; logic [7:0] d;} wr_t;
  typedef struct {int cyc; logic [NO-1:0] os;} dn_t;
  wr_t wq[$];
  dn_t dq[$];
  wr_t we_e;
  dn_t dn_e;
  int checks = 0, failures = 0, bc = 0;

  snn_layer_sched #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .DW(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .in_spikes(in_spikes), .beta(beta), .v_th(v_th),
    .busy(busy), .done(done), .out_spikes(out_spikes), .w_addr(w_addr), .w_rdata(w_rdata),
    .vm_addr(vm_addr), .vm_rdata(vm_rdata), .vm_we(vm_we), .vm_wdata(vm_wdata),
    .nrn_weight(nrn_weight), .nrn_v_mem_in(nrn_v_mem_in), .nrn_beta(nrn_beta), .nrn_v_th(nrn_v_th),
    .nrn_function_sel(nrn_function_sel), .nrn_spike(nrn_spike), .nrn_v_mem_out(nrn_v_mem_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    w_rdata <= wram[w_addr];
    vm_rdata <= vram[vm_addr];
    if (vm_we) vram[vm_addr] <= vm_wdata;
    else if (vload) begin
      vram[0] <= vinit0;
      vram[1] <= vinit1;
    end
  end

  always_comb begin
    nsum = {1'b0, nrn_v_mem_in} + {1'b0, nrn_weight};
    nprod = 16'(nrn_v_mem_in) * 16'(nrn_beta);
    nrn_spike = nrn_function_sel && (nrn_v_mem_in > nrn_v_th);
    nrn_v_mem_out = !nrn_function_sel ? (nsum[8] ? 8'hff : nsum[7:0]) : (nrn_spike ? 8'h00 : nprod[15:8]);
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  task automatic push_w(input logic [0:0] a, input logic sel, input logic [2:0] wa, input logic [7:0] d);
    wq.push_back('{a, sel, wa, d});
  endtask

  task automatic push_d(input int cyc, input logic [NO-1:0] os);
    dq.push_back('{cyc, os});
  endtask

  task automatic load_v(input logic [7:0] v0, input logic [7:0] v1);
    @(negedge clk);
    vinit0 = v0;
    vinit1 = v1;
    vload = 1;
    @(negedge clk);
    vload = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=%0d required=<200", n);
    end
  endtask

  task automatic run(input logic [NI-1:0] s, input logic [7:0] b, input logic [7:0] th);
    @(negedge clk);
    in_spikes = s;
    beta = b;
    v_th = th;
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst) bc = 0;
    else begin
      if (busy) bc++;
      if (vm_we) begin
        if (wq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=addr%0h required=none", vm_addr);
        end else begin
          we_e = wq.pop_front();
          chk("vm_addr", 32'(vm_addr), 32'(we_e.a));
          chk("function_sel", 32'(nrn_function_sel), 32'(we_e.sel));
          if (!we_e.sel) chk("w_addr", 32'(w_addr), 32'(we_e.wa));
          else chk("leak_weight", 32'(nrn_weight), 32'd0);
          chk("vm_wdata", 32'(vm_wdata), 32'(we_e.d));
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          dn_e = dq.pop_front();
          chk("busy_cycles", 32'(bc), 32'(dn_e.cyc));
          chk("out_spikes", 32'(out_spikes), 32'(dn_e.os));
        end
        bc = 0;
      end
    end
  end

  initial begin
    for (int k = 0; k < 8; k++) wram[k] = 8'(k + 1);
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (10) @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
    chk("idle_vm_we", 32'(vm_we), 0);
    chk("idle_out_spikes", 32'(out_spikes), 0);
    load_v(8'd0, 8'd0);
    push_w(0, 0, 0, 1); push_w(1, 0, 1, 2); push_w(0, 0, 4, 6); push_w(1, 0, 5, 8);
    push_w(0, 1, 0, 3); push_w(1, 1, 0, 4);
    push_d(17, 2'b00);
    run(4'b0101, 8'd128, 8'd10);
    push_w(0, 1, 0, 1); push_w(1, 1, 0, 2);
    push_d(9, 2'b00);
    run(4'b0000, 8'd128, 8'd10);
    chk("leak_only_vram0", 32'(vram[0]), 1);
    chk("leak_only_vram1", 32'(vram[1]), 2);
    for (int k = 0; k < 8; k++) wram[k] = 8'd50;
    load_v(8'd0, 8'd0);
    push_w(0, 0, 0, 50); push_w(1, 0, 1, 50); push_w(0, 0, 2, 100); push_w(1, 0, 3, 100);
    push_w(0, 1, 0, 0); push_w(1, 1, 0, 0);
    push_d(17, 2'b11);
    run(4'b0011, 8'd128, 8'd60);
    chk("fire_vram0", 32'(vram[0]), 0);
    chk("fire_vram1", 32'(vram[1]), 0);
    chk("fire_out_spikes_hold", 32'(out_spikes), 32'b11);
    load_v(8'd0, 8'd0);
    push_w(0, 0, 0, 50);
    @(negedge clk);
    in_spikes = 4'b1111;
    v_th = 8'd60;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_vm_we", 32'(vm_we), 0);
    chk("abort_out_spikes", 32'(out_spikes), 0);
    @(negedge clk);
    chk("abort_vram0", 32'(vram[0]), 50);
    chk("abort_vram1", 32'(vram[1]), 0);
    load_v(8'd0, 8'd0);
    push_w(0, 0, 0, 50); push_w(1, 0, 1, 50); push_w(0, 1, 0, 25); push_w(1, 1, 0, 25);
    push_d(13, 2'b00);
    @(negedge clk);
    in_spikes = 4'b0001;
    beta = 8'd128;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done();
    start = 1;
    @(negedge clk);
    start = 0;
    chk("start_on_done_ignored", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("still_idle", 32'(busy), 0);
    chk("writes_consumed", 32'(wq.size()), 0);
    chk("dones_consumed", 32'(dq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
